// File: rtl/exc_ctrl_pkg.sv
// Shared definitions for the exception sequencer: CP0 cause codes, MEM flag bit
// positions, FSM encodings and the default handler vector.
package exc_defs;

  localparam logic [31:0] EXC_VECTOR_DEF = 32'hBFC00380;

  localparam logic [4:0] EXC_INT  = 5'h01;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0A;
  localparam logic [4:0] EXC_OV   = 5'h0C;
  localparam logic [4:0] EXC_TR   = 5'h0D;
  localparam logic [4:0] EXC_ADEL = 5'h0E;
  localparam logic [4:0] EXC_ADES = 5'h0F;
  localparam logic [4:0] EXC_ERET = 5'h10;

  localparam int unsigned BIT_IADDR = 0;
  localparam int unsigned BIT_RI    = 1;
  localparam int unsigned BIT_SYS   = 2;
  localparam int unsigned BIT_BP    = 3;
  localparam int unsigned BIT_OV    = 4;
  localparam int unsigned BIT_TR    = 5;
  localparam int unsigned BIT_LADDR = 6;
  localparam int unsigned BIT_SADDR = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TAKE  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Unmasked interrupt request: IE set, EXL clear, any enabled IP line high.
  function automatic logic int_pending(input logic [31:0] status, input logic [31:0] cause);
    return (|(cause[15:8] & status[15:8])) & status[0] & ~status[1];
  endfunction

endpackage

// File: rtl/exc_prio_enc.sv
// Fixed-priority cause selector: interrupt, then MEM flags in bit order, then ERET.
module exc_prio_enc
  import exc_defs::*;
(
  input  logic [7:0] exc,
  input  logic       eret,
  input  logic       int_pend,
  output logic       valid,
  output logic [4:0] code,
  output logic       inst_except
);

  always_comb begin
    valid       = 1'b1;
    code        = '0;
    inst_except = 1'b0;
    if (int_pend)              code = EXC_INT;
    else if (exc[BIT_IADDR]) begin
      code        = EXC_ADEL;
      inst_except = 1'b1;
    end
    else if (exc[BIT_RI])      code = EXC_RI;
    else if (exc[BIT_SYS])     code = EXC_SYS;
    else if (exc[BIT_BP])      code = EXC_BP;
    else if (exc[BIT_OV])      code = EXC_OV;
    else if (exc[BIT_TR])      code = EXC_TR;
    else if (exc[BIT_LADDR])   code = EXC_ADEL;
    else if (exc[BIT_SADDR])   code = EXC_ADES;
    else if (eret)             code = EXC_ERET;
    else                       valid = 1'b0;
  end

endmodule

// File: rtl/exc_ctrl.sv
// Exception/interrupt sequencer: one-cycle CP0 take + flush/redirect, then a
// stall held for DRAIN_CYCLES while the flushed pipeline empties.
module exc_ctrl
  import exc_defs::*;
#(
  parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEF,
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_pc_i,
  input  logic        mem_in_delayslot_i,
  input  logic [7:0]  mem_exc_i,
  input  logic        mem_eret_i,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  output logic [31:0] excepttype_o,
  output logic [31:0] current_inst_addr_o,
  output logic        is_in_delayslot_o,
  output logic        inst_except_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic        stall_req_o,
  output logic        busy_o
);

  localparam logic [3:0] DRAIN_LD = 4'(DRAIN_CYCLES);

  state_t     state;
  logic [3:0] cnt;
  logic       sel_valid;
  logic [4:0] sel_code;
  logic       sel_iexc;
  logic       int_pend;

  // Only IP/IM, EXL and IE matter here; the remaining CP0 bits are parked.
  logic unused_bits;
  assign unused_bits = ^{cp0_status_i[31:16], cp0_status_i[7:2],
                         cp0_cause_i[31:16], cp0_cause_i[7:0]};

  assign int_pend = int_pending(cp0_status_i, cp0_cause_i);

  exc_prio_enc u_prio (
    .exc         (mem_exc_i),
    .eret        (mem_eret_i),
    .int_pend    (int_pend),
    .valid       (sel_valid),
    .code        (sel_code),
    .inst_except (sel_iexc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= ST_IDLE;
      cnt                 <= '0;
      excepttype_o        <= '0;
      current_inst_addr_o <= '0;
      is_in_delayslot_o   <= 1'b0;
      inst_except_o       <= 1'b0;
      flush_o             <= 1'b0;
      new_pc_o            <= '0;
      stall_req_o         <= 1'b0;
      busy_o              <= 1'b0;
    end else begin
      // CP0/flush outputs are single-cycle pulses; cleared unless a take fires.
      excepttype_o        <= '0;
      current_inst_addr_o <= '0;
      is_in_delayslot_o   <= 1'b0;
      inst_except_o       <= 1'b0;
      flush_o             <= 1'b0;
      new_pc_o            <= '0;
      unique case (state)
        ST_IDLE: begin
          if (mem_valid_i && sel_valid) begin
            state               <= ST_TAKE;
            excepttype_o        <= {27'd0, sel_code};
            current_inst_addr_o <= mem_pc_i;
            is_in_delayslot_o   <= mem_in_delayslot_i;
            inst_except_o       <= sel_iexc;
            flush_o             <= 1'b1;
            new_pc_o            <= (sel_code == EXC_ERET) ? cp0_epc_i : EXC_VECTOR;
            stall_req_o         <= 1'b1;
            busy_o              <= 1'b1;
          end
        end
        ST_TAKE: begin
          if (DRAIN_LD == 4'd0) begin
            state       <= ST_IDLE;
            stall_req_o <= 1'b0;
            busy_o      <= 1'b0;
          end else begin
            state <= ST_DRAIN;
            cnt   <= DRAIN_LD;
          end
        end
        ST_DRAIN: begin
          if (cnt <= 4'd1) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            stall_req_o <= 1'b0;
            busy_o      <= 1'b0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
- Exception/interrupt sequencer between the MEM stage and the CP0 register file.
- Each cycle it collects exception flags from the committing instruction and pending hardware/timer interrupts, picks one cause by fixed priority, and drives the CP0 exception inputs for exactly one cycle.
- It also issues the pipeline flush and redirect PC (handler vector or EPC for ERET), then holds a stall while the flush drains.

Parameters:
- EXC_VECTOR, 32'hBFC00380, handler entry PC for all exceptions and interrupts.
- DRAIN_CYCLES, 2, cycles `stall_req_o` stays high after the take cycle; range 0..15.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- mem_valid_i  in  1  MEM stage holds a real instruction (not a bubble)
- mem_pc_i  in  32  PC of the MEM-stage instruction
- mem_in_delayslot_i  in  1  MEM instruction is in a branch delay slot
- mem_exc_i  in  8  flags: [0] inst addr err, [1] reserved inst, [2] syscall, [3] break, [4] overflow, [5] trap, [6] load addr err, [7] store addr err
- mem_eret_i  in  1  MEM instruction is ERET
- cp0_status_i  in  32  current CP0 Status
- cp0_cause_i  in  32  current CP0 Cause
- cp0_epc_i  in  32  current CP0 EPC, already forwarded by the caller
- excepttype_o  out  32  exception code to CP0; 0 = none
- current_inst_addr_o  out  32  faulting PC to CP0
- is_in_delayslot_o  out  1  delay-slot flag to CP0
- inst_except_o  out  1  cause is an instruction-fetch address error
- flush_o  out  1  one-cycle pipeline flush
- new_pc_o  out  32  redirect PC, valid while `flush_o` = 1
- stall_req_o  out  1  stall request to the pipeline controller
- busy_o  out  1  FSM is not in IDLE

Behaviour:
- All outputs are registered. Reset value of every output is 0, and the FSM goes to IDLE.
- Interrupt pending (int_pend) = OR(cause[15:8] & status[15:8]) & status[0] & ~status[1].
- Inputs are evaluated only in IDLE with `mem_valid_i` = 1. Otherwise all inputs are ignored.
- Priority, highest first, with the excepttype code sent to CP0:
  - interrupt 0x01
  - inst addr err 0x0E, with `inst_except_o` = 1
  - reserved inst 0x0A
  - syscall 0x08
  - break 0x09
  - overflow 0x0C
  - trap 0x0D
  - load addr err 0x0E
  - store addr err 0x0F
  - eret 0x10
- When any cause is selected at cycle N, the FSM goes IDLE -> TAKE. During cycle N+1 (TAKE):
  - `excepttype_o` = code; `current_inst_addr_o` = `mem_pc_i`; `is_in_delayslot_o` = `mem_in_delayslot_i`
  - `flush_o` = 1, `stall_req_o` = 1, `busy_o` = 1
  - `new_pc_o` = `cp0_epc_i` sampled at N for ERET, otherwise EXC_VECTOR
- All of the above except `stall_req_o` and `busy_o` are high/valid for exactly one cycle. CP0 updates on the edge ending N+1.
- TAKE -> DRAIN, with a down-counter loaded with DRAIN_CYCLES. `stall_req_o` = 1 and other outputs are 0 while in DRAIN.
- DRAIN -> IDLE when the counter reaches 0. With DRAIN_CYCLES = 0, TAKE goes straight to IDLE.
- Inputs during TAKE/DRAIN are dropped, not queued; the flushed pipeline re-presents them.
- Status.EXL = 1: interrupts are masked. Synchronous exceptions are still taken; CP0 keeps the old EPC.
- Interrupt with simultaneous ERET or other flags: the interrupt wins, and EPC = PC of that instruction.
- `rst` mid-TAKE or mid-DRAIN: immediate return to IDLE with all outputs 0, no partial take.

Decomposition:
- Package `exc_defs`:
  - excepttype codes (0x01, 0x08-0x10)
  - `mem_exc_i` bit indices
  - FSM state encodings IDLE/TAKE/DRAIN
  - default EXC_VECTOR
- Sub-module `exc_prio_enc`: combinational priority encoder, {`mem_exc_i`, `mem_eret_i`, int_pend} -> {valid, code, inst_except}.

Test Plan:
- Syscall only (mem_exc=8'h04, pc=0x80000100, valid=1) -> next cycle excepttype=0x08, current_inst_addr=0x80000100, flush=1, new_pc=0xBFC00380; stall high for 3 cycles total.
- Overflow with bits [4] and [2] both set -> excepttype=0x08 (syscall beats overflow).
- Interrupt: status=0x0000FF01, cause[10]=1, with ERET at pc 0x80000200 -> excepttype=0x01 and new_pc=0xBFC00380; the same stimulus with status[1]=1 -> excepttype=0x10, new_pc=cp0_epc_i.
- Inst addr err at pc 0x80000300, in delay slot -> excepttype=0x0E, inst_except=1, is_in_delayslot=1.
- Load addr err presented during DRAIN -> ignored, no second flush; the same input with valid=0 in IDLE -> no response.
- `rst` asserted during DRAIN -> next cycle all outputs 0, busy=0; an exception accepted normally on the following cycle.
